// File: rtl/leaf_tx_packer.sv
// Packs 32-bit user words into 49-bit BFT packets {vld, leaf, port, addr, payload}; 1-cycle latency.
// Backpressure: ready drops when credit is exhausted or a held packet is not being consumed.
module leaf_tx_packer #(
  parameter int PACKET_BITS   = 49,
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_LEAF_BITS = 5,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_ADDR_BITS = 7,
  parameter int CREDIT_MAX    = 64,
  parameter int CREDIT_BITS   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_LEAF_BITS-1:0] i_dest_leaf,
  input  logic [NUM_PORT_BITS-1:0] i_dest_port,
  input  logic [PAYLOAD_BITS-1:0]  i_user_data,
  input  logic                     i_user_valid,
  output logic                     o_user_ready,
  output logic [PACKET_BITS-1:0]   o_bft_data,
  input  logic                     i_bft_ready,
  input  logic                     i_credit_valid,
  input  logic [NUM_ADDR_BITS-1:0] i_credit_count,
  output logic [CREDIT_BITS-1:0]   o_credit,
  output logic                     o_credit_err
);

  localparam logic [CREDIT_BITS:0] CREDIT_MAX_W = (CREDIT_BITS+1)'(CREDIT_MAX);

  logic [PACKET_BITS-1:0]   pkt_q, pkt_d;
  logic [NUM_ADDR_BITS-1:0] addr_q, addr_d;
  logic [CREDIT_BITS-1:0]   credit_q, credit_d;
  logic                     err_q, err_d;

  logic                     pkt_vld;
  logic                     accept;
  logic [CREDIT_BITS:0]     credit_ret;
  logic [CREDIT_BITS:0]     credit_sum;

  assign pkt_vld = pkt_q[PACKET_BITS-1];

  // Gated by reset so nothing is offered while the block is held in reset.
  assign o_user_ready = reset && (credit_q != '0) && (!pkt_vld || i_bft_ready);
  assign accept       = i_user_valid && o_user_ready;

  always_comb begin
    pkt_d  = pkt_q;
    addr_d = addr_q;
    if (accept) begin
      pkt_d  = {1'b1, i_dest_leaf, i_dest_port, addr_q, i_user_data};
      addr_d = addr_q + NUM_ADDR_BITS'(1);
    end else if (pkt_vld && i_bft_ready) begin
      pkt_d = '0;
    end
  end

  // One bit of headroom so an over-return is detected rather than wrapped.
  always_comb begin
    credit_ret = '0;
    if (i_credit_valid) begin
      credit_ret = {{(CREDIT_BITS+1-NUM_ADDR_BITS){1'b0}}, i_credit_count};
    end
    credit_sum = {1'b0, credit_q} - {{CREDIT_BITS{1'b0}}, accept} + credit_ret;
    credit_d   = credit_sum[CREDIT_BITS-1:0];
    err_d      = err_q;
    if (credit_sum > CREDIT_MAX_W) begin
      credit_d = CREDIT_MAX_W[CREDIT_BITS-1:0];
      err_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_q    <= '0;
      addr_q   <= '0;
      credit_q <= CREDIT_MAX_W[CREDIT_BITS-1:0];
      err_q    <= 1'b0;
    end else begin
      pkt_q    <= pkt_d;
      addr_q   <= addr_d;
      credit_q <= credit_d;
      err_q    <= err_d;
    end
  end

  assign o_bft_data   = pkt_q;
  assign o_credit     = credit_q;
  assign o_credit_err = err_q;

endmodule

// File: tb/tb_leaf_tx_packer.sv
// Bench for leaf_tx_packer: constant vector table, directed corner sequences, random traffic vs model.
module tb_leaf_tx_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  i_dest_leaf;
  logic [3:0]  i_dest_port;
  logic [31:0] i_user_data;
  logic        i_user_valid;
  logic        o_user_ready;
  logic [48:0] o_bft_data;
  logic        i_bft_ready;
  logic        i_credit_valid;
  logic [6:0]  i_credit_count;
  logic [7:0]  o_credit;
  logic        o_credit_err;

  always #5 clk = ~clk;

  leaf_tx_packer dut (
    .clk(clk), .reset(reset),
    .i_dest_leaf(i_dest_leaf), .i_dest_port(i_dest_port),
    .i_user_data(i_user_data), .i_user_valid(i_user_valid), .o_user_ready(o_user_ready),
    .o_bft_data(o_bft_data), .i_bft_ready(i_bft_ready),
    .i_credit_valid(i_credit_valid), .i_credit_count(i_credit_count),
    .o_credit(o_credit), .o_credit_err(o_credit_err)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: integers and a plain packet image.
  bit          m_vld;
  logic [48:0] m_pkt;
  int          m_addr;
  int          m_credit;
  bit          m_err;
  int          acc_count;
  bit          last_ready;

  function automatic logic [48:0] mkpkt(input logic [4:0] leaf, input logic [3:0] port,
                                        input int addr, input logic [31:0] d);
    logic [6:0] a;
    a = 7'(addr % 128);
    return {1'b1, leaf, port, a, d};
  endfunction

  function automatic bit m_ready();
    return reset && (m_credit > 0) && (!m_vld || i_bft_ready);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_vld = 0; m_pkt = '0; m_addr = 0; m_credit = 64; m_err = 0;
  endtask

  task automatic model_edge();
    bit acc;
    acc = i_user_valid && m_ready();
    if (acc) begin
      m_pkt  = mkpkt(i_dest_leaf, i_dest_port, m_addr, i_user_data);
      m_vld  = 1;
      m_addr = (m_addr + 1) % 128;
      acc_count++;
    end else if (m_vld && i_bft_ready) begin
      m_vld = 0;
      m_pkt = '0;
    end
    m_credit = m_credit - int'(acc) + (i_credit_valid ? int'(i_credit_count) : 0);
    if (m_credit > 64) begin
      m_credit = 64;
      m_err    = 1;
    end
  endtask

  task automatic set_in(input bit v, input int leaf, input int port, input logic [31:0] d,
                        input bit br, input bit cv, input int cc);
    i_user_valid = v; i_dest_leaf = 5'(leaf); i_dest_port = 4'(port); i_user_data = d;
    i_bft_ready = br; i_credit_valid = cv; i_credit_count = 7'(cc);
  endtask

  // One clock, entered shortly after a rising edge; checks against the model.
  task automatic cyc(input bit v, input int leaf, input int port, input logic [31:0] d,
                     input bit br, input bit cv, input int cc);
    set_in(v, leaf, port, d, br, cv, cc);
    #1;
    last_ready = o_user_ready;
    chk("ready", o_user_ready, m_ready());
    model_edge();
    @(posedge clk); #1;
    chk("pkt", o_bft_data, m_pkt);
    chk("credit", o_credit, 64'(m_credit));
    chk("err", o_credit_err, m_err);
  endtask

  task automatic apply_reset();
    set_in(0, 0, 0, 32'h0, 0, 0, 0);
    reset = 1'b0;
    #1;
    chk("rst_ready", o_user_ready, 0);
    chk("rst_pkt", o_bft_data, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_credit", o_credit, 64);
    chk("rst_err", o_credit_err, 0);
    model_reset();
    reset = 1'b1;
  endtask

  typedef struct {
    bit          v;
    logic [4:0]  leaf;
    logic [3:0]  port;
    logic [31:0] data;
    bit          br;
    bit          cv;
    logic [6:0]  cc;
    bit          exp_ready;
    logic [48:0] exp_pkt;
    logic [7:0]  exp_credit;
    bit          exp_err;
  } vec_t;

  vec_t tv[6];
  logic [48:0] held;

  initial begin
    tv[0] = '{1, 5'd5, 4'd3, 32'hDEADBEEF, 1, 0, 7'd0, 1,
              {1'b1, 5'd5, 4'd3, 7'd0, 32'hDEADBEEF}, 8'd63, 0};
    tv[1] = '{1, 5'd1, 4'd2, 32'h11111111, 0, 0, 7'd0, 0,
              {1'b1, 5'd5, 4'd3, 7'd0, 32'hDEADBEEF}, 8'd63, 0};
    tv[2] = '{0, 5'd0, 4'd0, 32'h0, 1, 1, 7'd1, 1, 49'd0, 8'd64, 0};
    tv[3] = '{0, 5'd0, 4'd0, 32'h0, 0, 1, 7'd10, 1, 49'd0, 8'd64, 1};
    tv[4] = '{1, 5'd31, 4'd15, 32'hCAFEF00D, 0, 1, 7'd1, 1,
              {1'b1, 5'd31, 4'd15, 7'd1, 32'hCAFEF00D}, 8'd64, 1};
    tv[5] = '{1, 5'd2, 4'd4, 32'h12345678, 1, 0, 7'd0, 1,
              {1'b1, 5'd2, 4'd4, 7'd2, 32'h12345678}, 8'd63, 1};

    reset = 1'b1;
    acc_count = 0;
    model_reset();
    set_in(0, 0, 0, 32'h0, 0, 0, 0);
    @(posedge clk); #1;
    apply_reset();
    @(posedge clk); #1;

    // Constant vector table.
    foreach (tv[i]) begin
      set_in(tv[i].v, tv[i].leaf, tv[i].port, tv[i].data, tv[i].br, tv[i].cv, tv[i].cc);
      #1;
      chk($sformatf("tv%0d_ready", i), o_user_ready, tv[i].exp_ready);
      model_edge();
      @(posedge clk); #1;
      chk($sformatf("tv%0d_pkt", i), o_bft_data, tv[i].exp_pkt);
      chk($sformatf("tv%0d_credit", i), o_credit, tv[i].exp_credit);
      chk($sformatf("tv%0d_err", i), o_credit_err, tv[i].exp_err);
    end
    // Error flag is sticky through idle cycles.
    repeat (3) cyc(0, 0, 0, 32'h0, 1, 0, 0);
    chk("err_sticky", o_credit_err, 1);

    // Hold: packet stays bit-stable and ready stays low while network stalls.
    apply_reset();
    cyc(1, 9, 6, 32'hA5A5A5A5, 1, 0, 0);
    held = o_bft_data;
    for (int k = 0; k < 5; k++) begin
      cyc(1, 3, 1, 32'h5A5A0000 + k, 0, 0, 0);
      chk("hold_stable", o_bft_data, held);
      chk("hold_ready", last_ready, 0);
    end
    cyc(1, 4, 2, 32'hBBBB0001, 1, 0, 0);
    chk("hold_b2b", o_bft_data, {1'b1, 5'd4, 4'd2, 7'd1, 32'hBBBB0001});

    // Credit exhaustion and single-credit release.
    apply_reset();
    for (int k = 0; k < 64; k++) cyc(1, 1, 1, 32'(k), 1, 0, 0);
    chk("exh_credit", o_credit, 0);
    acc_count = 0;
    cyc(1, 1, 1, 32'h0F0F0F0F, 1, 1, 1);
    chk("exh_ready0", last_ready, 0);
    cyc(1, 1, 1, 32'h0E0E0E0E, 1, 0, 0);
    chk("exh_ready1", last_ready, 1);
    repeat (3) cyc(1, 1, 1, 32'h0D0D0D0D, 1, 0, 0);
    chk("exh_one_accept", acc_count, 1);

    // Address roll-over across 130 back-to-back packets.
    apply_reset();
    acc_count = 0;
    for (int k = 0; k < 130; k++) begin
      cyc(1, k % 32, k % 16, 32'h1000 + k, 1, (k % 2) == 1, 2);
      chk($sformatf("roll_addr%0d", k), o_bft_data[38:32], 64'(k % 128));
    end
    chk("roll_count", acc_count, 130);

    // Reset asserted while a packet is held.
    apply_reset();
    cyc(1, 6, 6, 32'h66666666, 0, 0, 0);
    cyc(1, 6, 6, 32'h77777777, 0, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_pkt", o_bft_data, 0);
    chk("mid_rst_ready", o_user_ready, 0);
    chk("mid_rst_credit", o_credit, 64);
    @(posedge clk); #1;
    model_reset();
    reset = 1'b1;
    cyc(1, 7, 8, 32'h88888888, 1, 0, 0);
    chk("mid_rst_addr0", o_bft_data, {1'b1, 5'd7, 4'd8, 7'd0, 32'h88888888});

    // Random traffic against the model.
    apply_reset();
    for (int k = 0; k < 3000; k++) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 31), $urandom_range(0, 15), $urandom,
          $urandom_range(0, 4) < 3, $urandom_range(0, 4) == 0, $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
